// File: rtl/lockpick_pkg.sv
// lockpick_pkg: screen codes, keycodes, geometry constants and pick-step helpers
package lockpick_pkg;
  typedef enum logic [2:0] {
    SCR_TITLE  = 3'b000,
    SCR_LEVEL1 = 3'b001,
    SCR_LEVEL2 = 3'b010,
    SCR_FAIL   = 3'b100,
    SCR_WIN    = 3'b111
  } screen_t;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_ESC = 8'h29;
  localparam logic [9:0] PICK_START_X = 10'd320;
  localparam logic [9:0] PICK_START_Y = 10'd240;
  localparam logic [9:0] STEP = 10'd2;
  localparam logic [9:0] X_MAX = 10'd639;
  localparam logic [9:0] Y_MAX = 10'd479;
  localparam logic [9:0] TGT1_X = 10'd400;
  localparam logic [9:0] TGT1_Y = 10'd300;
  localparam logic [9:0] TGT2_X = 10'd150;
  localparam logic [9:0] TGT2_Y = 10'd100;
  localparam logic [10:0] TOL = 11'd8;
  localparam logic [5:0] HOLD_FRAMES = 6'd60;
  localparam logic [10:0] LEVEL_FRAMES = 11'd1800;
  function automatic logic [9:0] step_dn(input logic [9:0] v);
    return v < STEP ? 10'd0 : v - STEP;
  endfunction
  function automatic logic [9:0] step_up(input logic [9:0] v, input logic [9:0] lim);
    return v > lim - STEP ? lim : v + STEP;
  endfunction
  function automatic logic in_tol(input logic [9:0] v, input logic [9:0] c);
    logic [10:0] a, b;
    a = {1'b0, v};
    b = {1'b0, c};
    return (a > b ? a - b : b - a) <= TOL;
  endfunction
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered previous sample, combinational rising-edge pulse
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev_q;
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else prev_q <= d;
  end
  assign rise = d & ~prev_q;
endmodule

// File: rtl/lockpick_game_ctrl.sv
// lockpick_game_ctrl: screen sequencer, pick movement, hold counter and level timer
module lockpick_game_ctrl
  import lockpick_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  output logic [2:0]  currScreen,
  output logic [9:0]  PickX,
  output logic [9:0]  PickY,
  output logic [10:0] frames_left,
  output logic [5:0]  hold_cnt
);
  screen_t screen_q, screen_d;
  logic [9:0] x_q, x_d, y_q, y_d, mx, my;
  logic [10:0] frames_q, frames_d;
  logic [5:0] hold_q, hold_d, hold_nx;
  logic tick, enter, is_enter, esc, in_win;
  assign is_enter = keycode == KEY_ENTER;
  assign esc = keycode == KEY_ESC;
  rise_detect u_frame (.clk(Clk), .rst(Reset), .d(frame_clk), .rise(tick));
  rise_detect u_enter (.clk(Clk), .rst(Reset), .d(is_enter), .rise(enter));
  always_comb begin
    in_win = screen_q == SCR_LEVEL2 ? in_tol(x_q, TGT2_X) && in_tol(y_q, TGT2_Y)
                                    : in_tol(x_q, TGT1_X) && in_tol(y_q, TGT1_Y);
    hold_nx = in_win ? hold_q + 6'd1 : 6'd0;
    mx = keycode == KEY_A ? step_dn(x_q) : keycode == KEY_D ? step_up(x_q, X_MAX) : x_q;
    my = keycode == KEY_W ? step_dn(y_q) : keycode == KEY_S ? step_up(y_q, Y_MAX) : y_q;
    screen_d = screen_q;
    x_d = x_q;
    y_d = y_q;
    frames_d = frames_q;
    hold_d = hold_q;
    case (screen_q)
      SCR_TITLE: if (enter) begin
        screen_d = SCR_LEVEL1;
        x_d = PICK_START_X;
        y_d = PICK_START_Y;
        frames_d = LEVEL_FRAMES;
        hold_d = 6'd0;
      end
      SCR_LEVEL1, SCR_LEVEL2: if (esc) begin
        screen_d = SCR_TITLE;
        x_d = PICK_START_X;
        y_d = PICK_START_Y;
        frames_d = 11'd0;
        hold_d = 6'd0;
      end else if (tick) begin
        x_d = mx;
        y_d = my;
        hold_d = hold_nx;
        frames_d = frames_q - 11'd1;
        // hold completion wins over a timeout landing on the same tick
        if (hold_nx == HOLD_FRAMES) begin
          hold_d = 6'd0;
          if (screen_q == SCR_LEVEL1) begin
            screen_d = SCR_LEVEL2;
            x_d = PICK_START_X;
            y_d = PICK_START_Y;
            frames_d = LEVEL_FRAMES;
          end else begin
            screen_d = SCR_WIN;
            frames_d = 11'd0;
          end
        end else if (frames_q == 11'd1) begin
          screen_d = SCR_FAIL;
        end
      end
      SCR_WIN, SCR_FAIL: if (enter) begin
        screen_d = SCR_TITLE;
        x_d = PICK_START_X;
        y_d = PICK_START_Y;
        frames_d = 11'd0;
        hold_d = 6'd0;
      end
      default: begin
        screen_d = SCR_TITLE;
        x_d = PICK_START_X;
        y_d = PICK_START_Y;
        frames_d = 11'd0;
        hold_d = 6'd0;
      end
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      screen_q <= SCR_TITLE;
      x_q <= PICK_START_X;
      y_q <= PICK_START_Y;
      frames_q <= 11'd0;
      hold_q <= 6'd0;
    end else begin
      screen_q <= screen_d;
      x_q <= x_d;
      y_q <= y_d;
      frames_q <= frames_d;
      hold_q <= hold_d;
    end
  end
  assign currScreen = screen_q;
  assign PickX = x_q;
  assign PickY = y_q;
  assign frames_left = frames_q;
  assign hold_cnt = hold_q;
endmodule

// File: tb/tb_lockpick_game_ctrl.sv
// tb_lockpick_game_ctrl: directed vectors with hand-computed expectations
module tb_lockpick_game_ctrl;
  logic clk = 1'b0;
  logic rst, frame_clk;
  logic [7:0] keycode;
  logic [2:0] scr;
  logic [9:0] px, py;
  logic [10:0] fl;
  logic [5:0] hc;
  int checks = 0, errors = 0;
  lockpick_game_ctrl dut (
    .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(keycode),
    .currScreen(scr), .PickX(px), .PickY(py), .frames_left(fl), .hold_cnt(hc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic ticks(input logic [7:0] k, input int n, input int w = 1);
    keycode = k;
    for (int i = 0; i < n; i++) begin
      @(negedge clk) frame_clk = 1'b1;
      repeat (w) @(negedge clk);
      frame_clk = 1'b0;
    end
    @(negedge clk);
    keycode = 8'h00;
  endtask
  task automatic press(input logic [7:0] k);
    @(negedge clk) keycode = k;
    @(negedge clk) keycode = 8'h00;
  endtask
  task automatic to_level2;
    press(8'h28);
    ticks(8'h07, 40);
    ticks(8'h16, 30);
    ticks(8'h00, 56);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scr", scr, 0);
    chk("rst_x", px, 320);
    chk("rst_y", py, 240);
    chk("rst_fl", fl, 0);
    chk("rst_hc", hc, 0);
    rst = 1'b0;
    @(negedge clk) keycode = 8'h28;
    @(negedge clk);
    chk("enter_scr", scr, 1);
    chk("enter_fl", fl, 1800);
    repeat (9) @(negedge clk);
    keycode = 8'h00;
    chk("enter_hold_scr", scr, 1);
    chk("enter_hold_fl", fl, 1800);
    chk("enter_x", px, 320);
    chk("enter_y", py, 240);
    ticks(8'h07, 40);
    chk("d40_x", px, 400);
    chk("d40_fl", fl, 1760);
    ticks(8'h16, 30);
    chk("s30_y", py, 300);
    chk("s30_hc", hc, 4);
    chk("s30_fl", fl, 1730);
    ticks(8'h00, 55);
    chk("hold59_hc", hc, 59);
    chk("hold59_scr", scr, 1);
    ticks(8'h00, 1);
    chk("l2_scr", scr, 2);
    chk("l2_x", px, 320);
    chk("l2_y", py, 240);
    chk("l2_fl", fl, 1800);
    chk("l2_hc", hc, 0);
    ticks(8'h00, 4);
    chk("l2_fl4", fl, 1796);
    ticks(8'h00, 1795);
    chk("to_pre_scr", scr, 2);
    chk("to_pre_fl", fl, 1);
    ticks(8'h00, 1);
    chk("to_scr", scr, 4);
    chk("to_fl", fl, 0);
    ticks(8'h04, 3);
    chk("fail_frozen_x", px, 320);
    press(8'h28);
    chk("fail_enter_scr", scr, 0);
    chk("fail_enter_fl", fl, 0);
    press(8'h28);
    chk("clamp_scr", scr, 1);
    ticks(8'h04, 160);
    chk("a160_x", px, 0);
    ticks(8'h04, 5);
    chk("a_sat_x", px, 0);
    ticks(8'h07, 1, 4);
    chk("wide_pulse_x", px, 2);
    ticks(8'h07, 318);
    chk("d_638_x", px, 638);
    ticks(8'h07, 1);
    chk("d_639_x", px, 639);
    ticks(8'h07, 1);
    chk("d_sat_x", px, 639);
    ticks(8'h1A, 120);
    chk("w120_y", py, 0);
    ticks(8'h1A, 1);
    chk("w_sat_y", py, 0);
    chk("clamp_fl", fl, 1193);
    ticks(8'h2C, 293);
    chk("other_key_x", px, 639);
    chk("esc_pre_fl", fl, 900);
    @(negedge clk) keycode = 8'h29;
    @(negedge clk);
    chk("esc_scr", scr, 0);
    chk("esc_fl", fl, 0);
    chk("esc_x", px, 320);
    chk("esc_y", py, 240);
    keycode = 8'h00;
    to_level2();
    chk("co_l2_scr", scr, 2);
    ticks(8'h1A, 70);
    ticks(8'h04, 80);
    chk("co_x", px, 160);
    chk("co_y", py, 100);
    chk("co_hc0", hc, 0);
    ticks(8'h00, 1589);
    chk("co_fl61", fl, 61);
    ticks(8'h04, 5);
    chk("co_hc4", hc, 4);
    chk("co_x150", px, 150);
    ticks(8'h00, 55);
    chk("co_pre_fl", fl, 1);
    chk("co_pre_hc", hc, 59);
    ticks(8'h00, 1);
    chk("co_win_scr", scr, 7);
    chk("co_win_fl", fl, 0);
    press(8'h28);
    chk("win_enter_scr", scr, 0);
    to_level2();
    ticks(8'h07, 10);
    chk("pre_rst_x", px, 340);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("mrst_scr", scr, 0);
    chk("mrst_x", px, 320);
    chk("mrst_y", py, 240);
    chk("mrst_fl", fl, 0);
    chk("mrst_hc", hc, 0);
    rst = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
